// File: rtl/ambient_pkg.sv
// Shared types and default widths for the ambient stimulus player.
package ambient_pkg;

    localparam int unsigned TEMP_W_DEF = 6;
    localparam int unsigned HUM_W_DEF  = 7;
    localparam int unsigned LUM_W_DEF  = 10;
    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned GAP_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

endpackage

// File: rtl/sample_table.sv
// Sample storage: one synchronous write port, one asynchronous read port.
module sample_table #(
    parameter  int unsigned W     = 23,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic [W-1:0]     rd_data_o
);

    logic [W-1:0] r_mem [DEPTH];

    // Table write; contents intentionally carry no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/ambient_stimulus_player.sv
// Replays stored ambient samples over valid/ready with a programmable idle gap.
module ambient_stimulus_player
    import ambient_pkg::*;
#(
    parameter  int unsigned TEMP_W = TEMP_W_DEF,
    parameter  int unsigned HUM_W  = HUM_W_DEF,
    parameter  int unsigned LUM_W  = LUM_W_DEF,
    parameter  int unsigned DEPTH  = DEPTH_DEF,
    parameter  int unsigned GAP_W  = GAP_W_DEF,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W  = $clog2(DEPTH),
    localparam int unsigned SMP_W  = TEMP_W + HUM_W + LUM_W
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              enable_i,
    input  logic              loop_i,
    input  logic [GAP_W-1:0]  gap_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [TEMP_W-1:0] wr_temp_i,
    input  logic [HUM_W-1:0]  wr_hum_i,
    input  logic [LUM_W-1:0]  wr_lum_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [TEMP_W-1:0] temperature_o,
    output logic [HUM_W-1:0]  humidity_o,
    output logic [LUM_W-1:0]  luminous_intensity_o,
    output logic [IDX_W-1:0]  sample_idx_o,
    output logic              busy_o,
    output logic              done_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_loop;
    logic [GAP_W-1:0]   r_gap;
    logic [CNT_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_valid;
    logic [TEMP_W-1:0]  r_temp;
    logic [HUM_W-1:0]   r_hum;
    logic [LUM_W-1:0]   r_lum;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_eff_count;
    logic               w_start;
    logic               w_xfer;
    logic               w_last;
    logic [IDX_W-1:0]   w_adv_idx;
    logic               w_gap_end;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [SMP_W-1:0]   w_rd_data;
    logic [TEMP_W-1:0]  w_rd_temp;
    logic [HUM_W-1:0]   w_rd_hum;
    logic [LUM_W-1:0]   w_rd_lum;
    logic               w_load;
    logic               w_cfg_load;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [GAP_W-1:0]   w_gap_cnt_nxt;
    logic               w_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    assign w_eff_count = (count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_i;
    assign w_start     = enable_i && (w_eff_count != '0);
    assign w_xfer      = r_valid && ready_i;
    assign w_last      = (r_idx == IDX_W'(r_count - CNT_W'(1)));
    assign w_adv_idx   = w_last ? '0 : r_idx + IDX_W'(1);
    assign w_gap_end   = (r_gap_cnt == GAP_W'(1));

    // Writes are only taken while idle so a running replay never sees them.
    sample_table #(
        .W     (SMP_W),
        .DEPTH (DEPTH)
    ) u_table (
        .clk_i     (clk_i),
        .wr_en_i   (wr_en_i && !r_busy),
        .wr_addr_i (wr_addr_i),
        .wr_data_i ({wr_temp_i, wr_hum_i, wr_lum_i}),
        .rd_addr_i (w_rd_idx),
        .rd_data_o (w_rd_data)
    );

    assign {w_rd_temp, w_rd_hum, w_rd_lum} = w_rd_data;

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: a presented sample is never withdrawn before its transfer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (w_xfer) begin
                    if ((w_last && !r_loop) || !enable_i) begin
                        w_state_nxt = IDLE;
                    end else if (r_gap == '0) begin
                        w_state_nxt = PRESENT;
                    end else begin
                        w_state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                if (!enable_i) begin
                    w_state_nxt = IDLE;
                end else if (w_gap_end) begin
                    w_state_nxt = PRESENT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output/datapath next values; index advances at transfer so GAP already points at the next entry.
    always_comb begin
        w_rd_idx      = r_idx;
        w_load        = 1'b0;
        w_cfg_load    = 1'b0;
        w_idx_nxt     = r_idx;
        w_gap_cnt_nxt = r_gap_cnt;
        w_done_nxt    = 1'b0;
        w_valid_nxt   = (w_state_nxt == PRESENT);
        w_busy_nxt    = (w_state_nxt != IDLE);
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_cfg_load = 1'b1;
                    w_rd_idx   = '0;
                    w_idx_nxt  = '0;
                    w_load     = 1'b1;
                end
            end
            PRESENT: begin
                if (w_xfer) begin
                    w_rd_idx      = w_adv_idx;
                    w_idx_nxt     = w_adv_idx;
                    w_gap_cnt_nxt = r_gap;
                    w_load        = (w_state_nxt == PRESENT);
                    w_done_nxt    = w_last && !r_loop;
                end
            end
            GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
                w_load        = (w_state_nxt == PRESENT);
            end
            default: ;
        endcase
    end

    // Registered outputs and run configuration.
    always_ff @(posedge clk_i) begin
        if (reset_n) begin
            r_loop    <= 1'b0;
            r_gap     <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_valid   <= 1'b0;
            r_temp    <= '0;
            r_hum     <= '0;
            r_lum     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_cfg_load) begin
                r_loop  <= loop_i;
                r_gap   <= gap_i;
                r_count <= w_eff_count;
            end
            if (w_load) begin
                r_temp <= w_rd_temp;
                r_hum  <= w_rd_hum;
                r_lum  <= w_rd_lum;
            end
            r_idx     <= w_idx_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign valid_o              = r_valid;
    assign temperature_o        = r_temp;
    assign humidity_o           = r_hum;
    assign luminous_intensity_o = r_lum;
    assign sample_idx_o         = r_idx;
    assign busy_o               = r_busy;
    assign done_o               = r_done;

endmodule

// File: tb/tb_ambient_stimulus_player.sv
// Scoreboard bench for ambient_stimulus_player: directed runs, monitor checks every transfer.
module tb_ambient_stimulus_player;

    localparam int unsigned TW = 6;
    localparam int unsigned HW = 7;
    localparam int unsigned LW = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned GW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable_i = 1'b0;
    logic          loop_i = 1'b0;
    logic [GW-1:0] gap_i = '0;
    logic [CW-1:0] count_i = '0;
    logic          wr_en_i = 1'b0;
    logic [IW-1:0] wr_addr_i = '0;
    logic [TW-1:0] wr_temp_i = '0;
    logic [HW-1:0] wr_hum_i = '0;
    logic [LW-1:0] wr_lum_i = '0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [TW-1:0] temperature_o;
    logic [HW-1:0] humidity_o;
    logic [LW-1:0] luminous_intensity_o;
    logic [IW-1:0] sample_idx_o;
    logic          busy_o;
    logic          done_o;

    ambient_stimulus_player dut (
        .clk_i                (clk),
        .reset_n              (reset_n),
        .enable_i             (enable_i),
        .loop_i               (loop_i),
        .gap_i                (gap_i),
        .count_i              (count_i),
        .wr_en_i              (wr_en_i),
        .wr_addr_i            (wr_addr_i),
        .wr_temp_i            (wr_temp_i),
        .wr_hum_i             (wr_hum_i),
        .wr_lum_i             (wr_lum_i),
        .ready_i              (ready_i),
        .valid_o              (valid_o),
        .temperature_o        (temperature_o),
        .humidity_o           (humidity_o),
        .luminous_intensity_o (luminous_intensity_o),
        .sample_idx_o         (sample_idx_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TW-1:0] t;
        logic [HW-1:0] h;
        logic [LW-1:0] l;
        logic [IW-1:0] idx;
    } exp_t;

    // Reference sample table
    int tv [8] = '{23, 26, 18, 15, 20, 25, 30, 35};
    int hv [8] = '{55, 40, 30, 30, 40, 50, 60, 70};
    int lv [8] = '{500, 702, 250, 300, 400, 500, 600, 700};

    exp_t sb [$];
    int   xfer_cyc [$];
    int   done_cyc = -1;
    int   ndone = 0;
    int   total = 0;
    int   bad = 0;
    int   start_cyc = 0;

    bit            hold = 1'b0;
    logic [TW-1:0] h_t;
    logic [HW-1:0] h_h;
    logic [LW-1:0] h_l;
    logic [IW-1:0] h_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e.t = TW'(tv[i]);
        e.h = HW'(hv[i]);
        e.l = LW'(lv[i]);
        e.idx = IW'(i);
        sb.push_back(e);
    endtask

    task automatic write_entry(input int a, input int t, input int h, input int l);
        wr_en_i   = 1'b1;
        wr_addr_i = IW'(a);
        wr_temp_i = TW'(t);
        wr_hum_i  = HW'(h);
        wr_lum_i  = LW'(l);
        @(posedge clk); #1;
        wr_en_i   = 1'b0;
    endtask

    task automatic start(input int cnt, input bit lp, input int gap);
        count_i  = CW'(cnt);
        loop_i   = lp;
        gap_i    = GW'(gap);
        enable_i = 1'b1;
        start_cyc = cyc;
        xfer_cyc.delete();
    endtask

    task automatic run_until_done(input bit toggle, input int max);
        int n = 0;
        while (n < max) begin
            @(posedge clk); #1;
            if (done_o) break;
            if (toggle) ready_i = ~ready_i;
            n++;
        end
        enable_i = 1'b0;
        chk("run_timeout", 32'(n < max), 1);
        @(posedge clk); #1;
        chk("idle_after_done", busy_o, 0);
    endtask

    // Monitor: scoreboard pop on transfer, hold-stability while stalled, done bookkeeping
    always @(negedge clk) begin
        exp_t e;
        if (hold) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", {temperature_o, humidity_o, luminous_intensity_o, sample_idx_o},
                {h_t, h_h, h_l, h_i});
        end
        if (valid_o === 1'b1 && ready_i === 1'b1) begin
            xfer_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_xfer", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", {temperature_o, humidity_o, luminous_intensity_o, sample_idx_o},
                    {e.t, e.h, e.l, e.idx});
            end
        end
        if (done_o === 1'b1) begin
            ndone++;
            done_cyc = cyc;
        end
        hold = (valid_o === 1'b1) && !ready_i && !reset_n;
        h_t = temperature_o;
        h_h = humidity_o;
        h_l = luminous_intensity_o;
        h_i = sample_idx_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_idx", sample_idx_o, 0);
        chk("rst_data", {temperature_o, humidity_o, luminous_intensity_o}, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) write_entry(i, tv[i], hv[i], lv[i]);

        // Single shot, back-to-back
        for (int i = 0; i < 3; i++) push_exp(i);
        ready_i = 1'b1;
        start(3, 0, 0);
        run_until_done(0, 40);
        chk("s1_sb_empty", sb.size(), 0);
        chk("s1_nxfer", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("s1_latency", xfer_cyc[0] - start_cyc, 1);
            chk("s1_b2b", xfer_cyc[2] - xfer_cyc[0], 2);
            chk("s1_done_time", done_cyc - xfer_cyc[2], 1);
        end
        chk("s1_ndone", ndone, 1);

        // Gap of 4 with an ignored write while busy
        for (int i = 0; i < 3; i++) push_exp(i);
        start(3, 0, 4);
        @(posedge clk); #1;
        chk("s2_busy", busy_o, 1);
        write_entry(1, 1, 2, 3);
        run_until_done(0, 80);
        chk("s2_sb_empty", sb.size(), 0);
        chk("s2_nxfer", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("s2_gap01", xfer_cyc[1] - xfer_cyc[0], 5);
            chk("s2_gap12", xfer_cyc[2] - xfer_cyc[1], 5);
        end
        chk("s2_ndone", ndone, 2);

        // Ready toggling every cycle; entry 1 must still be the original
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push_exp(i);
        start(3, 0, 0);
        run_until_done(1, 60);
        ready_i = 1'b1;
        chk("s4_sb_empty", sb.size(), 0);
        chk("s4_nxfer", xfer_cyc.size(), 3);
        chk("s4_ndone", ndone, 3);

        // Loop over two entries, then drop enable while stalled
        for (int j = 0; j < 9; j++) push_exp(j % 2);
        start(2, 1, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("s3_nxfer8", xfer_cyc.size(), 8);
        chk("s3_valid", valid_o, 1);
        chk("s3_idx", sample_idx_o, 0);
        ready_i  = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("s3_busy_stalled", busy_o, 1);
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("s3_busy_end", busy_o, 0);
        chk("s3_valid_end", valid_o, 0);
        chk("s3_sb_empty", sb.size(), 0);
        chk("s3_ndone", ndone, 3);

        // Zero count never starts
        start(0, 0, 0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("s6_busy", busy_o, 0);
            chk("s6_valid", valid_o, 0);
        end
        enable_i = 1'b0;

        // Count beyond depth clamps to 8
        for (int i = 3; i < 8; i++) write_entry(i, tv[i], hv[i], lv[i]);
        for (int i = 0; i < 8; i++) push_exp(i);
        start(15, 0, 0);
        run_until_done(0, 40);
        chk("s7_sb_empty", sb.size(), 0);
        chk("s7_nxfer", xfer_cyc.size(), 8);
        chk("s7_ndone", ndone, 4);

        // Reset in the middle of PRESENT
        ready_i = 1'b0;
        start(3, 0, 0);
        @(posedge clk); #1;
        chk("s8_valid_pre", valid_o, 1);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("s8_valid", valid_o, 0);
        chk("s8_data", {temperature_o, humidity_o, luminous_intensity_o}, 0);
        chk("s8_idx", sample_idx_o, 0);
        chk("s8_busy", busy_o, 0);
        chk("s8_done", done_o, 0);
        reset_n  = 1'b0;
        enable_i = 1'b0;
        @(posedge clk); #1;
        chk("s8_idle", busy_o, 0);
        chk("s8_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ambient_stimulus_player.md
# ambient_stimulus_player

Synthesisable, parametrised playback engine for the ambient-control datapath. It stores up to DEPTH sensor samples, each a temperature, humidity and luminous-intensity triple, loaded through a write port. It replays them over a valid/ready handshake with a programmable idle gap between samples, in single-shot or loop mode. It sits in front of the ambient controller and drives the same sample bus the controller consumes, for bench and on-chip self-test use.

## Interface
- TEMP_W, 6, temperature sample width
- HUM_W, 7, humidity sample width
- LUM_W, 10, luminous-intensity sample width
- DEPTH, 8, sample table entries (≥2)
- GAP_W, 8, width of inter-sample gap counter
- clk_i  in  1  clock; everything is on its rising edge
- reset_n  in  1  synchronous, active-high reset (name kept for bus compatibility; 1 = reset)
- enable_i  in  1  run request
- loop_i  in  1  0 = single-shot, 1 = wrap to entry 0 after last entry
- gap_i  in  GAP_W  idle cycles inserted after each accepted sample
- count_i  in  $clog2(DEPTH+1)  number of table entries to play
- wr_en_i  in  1  table write strobe
- wr_addr_i  in  $clog2(DEPTH)  table write address
- wr_temp_i / wr_hum_i / wr_lum_i  in  TEMP_W / HUM_W / LUM_W  write data
- ready_i  in  1  consumer ready
- valid_o  out  1  sample valid
- temperature_o / humidity_o / luminous_intensity_o  out  TEMP_W / HUM_W / LUM_W  sample data
- sample_idx_o  out  $clog2(DEPTH)  index of the sample currently presented
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse at end of a single-shot run

## Operation
- FSM states: IDLE, PRESENT, GAP.
- IDLE: if enable_i=1 and the effective count is nonzero, latch loop_i, gap_i and count. Load entry 0, then go to PRESENT. The effective count is count_i clamped to DEPTH.
- PRESENT: valid_o=1 and data equal the table entry at sample_idx_o. Data and index stay stable until ready_i=1. A transfer is valid_o & ready_i.
- On transfer, if the current entry is not the last, increment the index. If gap=0, go to PRESENT with the next entry (back-to-back). If gap>0, go to GAP.
- On transfer of the last entry with loop=1, wrap the index to 0 and continue as above.
- On transfer of the last entry with loop=0, pulse done_o and go to IDLE.
- GAP: valid_o=0 for exactly gap cycles, then go to PRESENT with the next entry.
- enable_i deasserted during PRESENT: valid_o is never retracted. The pending sample completes its transfer, then the FSM goes to IDLE with no done_o.
- enable_i deasserted during GAP: go to IDLE on the next edge.
- Write port: accepted only when busy_o=0. Writes while busy are ignored.
- count_i=0 in IDLE: the FSM stays in IDLE.
- Table contents are not reset. Output data registers reset to 0.

## Timing
- Reset values: valid_o=0, data outputs=0, sample_idx_o=0, busy_o=0, done_o=0, FSM=IDLE. Reset overrides all other inputs in the same cycle, including mid-transfer.
- Start latency: enable_i sampled high in IDLE at edge N gives valid_o=1 with entry 0 after edge N (visible in cycle N+1).
- All outputs are registered. There is no combinational path from ready_i to any output.
- Back-to-back throughput (gap=0, ready_i held at 1): one sample per cycle.
- With gap=G, consecutive valid_o rises are G+1 cycles apart when ready_i is held at 1.
- done_o rises in the cycle after the last transfer, together with busy_o falling.
- A write to the table is visible to a run started on or after the next edge.

## Structure
- Shared package ambient_pkg holds the state enum (IDLE, PRESENT, GAP) and the default width constants (6/7/10).
- Sub-module sample_table stores DEPTH × (TEMP_W+HUM_W+LUM_W) bits. It has one synchronous write port and one asynchronous read port indexed by the next-sample index.
- The top level holds the FSM, index counter, gap counter and output registers.

## Test plan
- Load {23,55,500},{26,40,702},{18,30,250}, count=3, loop=0, gap=0, ready_i=1, enable_i pulsed high → three consecutive valid cycles carrying 23/55/500, 26/40/702, 18/30/250; done_o pulse on the next cycle; busy_o low.
- Same table, gap=4 → valid_o high 1 cycle, low 4 cycles, repeated; exactly 3 transfers.
- loop=1, count=2, enable_i held 8 transfers → sequence 23,26,23,26,… and no done_o; enable_i drops with valid_o high and ready_i=0 → data held until ready_i=1, then IDLE.
- ready_i toggling 0/1 every cycle → data and sample_idx_o stable while valid_o=1 & ready_i=0; no sample skipped or duplicated.
- Write to entry 1 while busy_o=1 → table unchanged on the next run.
- count_i=0 → FSM stays IDLE.
- count_i=15 with DEPTH=8 → 8 transfers.
- reset_n=1 mid-PRESENT → next cycle all outputs 0, FSM in IDLE.
